pc88_loader_sdram_bridge: RTL and testbench
===========================================

// Module: pc88_loader_sdram_bridge
// PURPOSE
//  Bridges the byte-wide loader handshake (LOADER_ADR/WDAT/WR/ACK/DONE) from the MiSTer shell into the 16-bit
//  SDRAM arbiter write port inside PC88MiSTer. Packs consecutive even/odd bytes into one word write and flushes
//  orphan bytes with a single-lane mask. Returns one ack per byte so the shell's ioctl_wait throttles HPS download.
// PARAMETERS
//  ADDR_W   19   loader byte-address width
//  MEM_AW   22   SDRAM word-address width
//  BASE     0    word offset added to every SDRAM address (ROM region base)
// PORTS
//  clk21m    in   1        system clock (all logic on this edge)
//  rstn      in   1        reset, asynchronous, active-low
//  ldr_oe    in   1        download window active
//  ldr_adr   in   ADDR_W   byte address, valid while ldr_wr=1
//  ldr_wdat  in   8        byte data, valid while ldr_wr=1
//  ldr_wr    in   1        level request, held until ldr_ack
//  ldr_ack   out  1        one-cycle pulse: byte consumed
//  ldr_done  in   1        download finished (level, sticky upstream)
//  mem_req   out  1        SDRAM write request, level
//  mem_adr   out  MEM_AW   word address = BASE + ldr_adr[ADDR_W-1:1]
//  mem_wdat  out  16       {odd byte, even byte}
//  mem_be    out  2        byte enables {hi,lo}
//  mem_ack   in   1        one-cycle pulse: write committed
//  busy      out  1        1 while a byte or partial word is pending
//  wr_count  out  16       SDRAM writes issued, wraps at 2^16
// BEHAVIOUR
//  - Reset (rstn=0, async): all outputs 0, state IDLE, pack register empty.
//  - States: IDLE, PACK, REQ, ACKB, FLUSH.
//  - IDLE: ldr_wr=1 & ldr_oe=1 -> latch adr/data.
//    -- If a partial word is held with a different word address, go FLUSH first; byte stays un-acked.
//    -- Even byte: store in lo lane, ldr_ack next cycle (PACK), return IDLE.
//    -- Odd byte: form word; be=11 if held lo matches the word, else be=10; go REQ.
//  - REQ: mem_req=1; mem_adr/wdat/be stable until mem_ack. On mem_ack, mem_req=0 next cycle, wr_count+1, then ACKB.
//  - ACKB: ldr_ack=1 for one cycle, partial cleared, -> IDLE.
//  - FLUSH: issue held lo byte with be=01 via the REQ handshake, no ldr_ack, -> IDLE.
//  - ldr_wr is never sampled in a cycle where ldr_ack=1 (upstream drops wr one cycle late).
//  - Rising ldr_done or falling ldr_oe with a partial held -> FLUSH. Neither ends a write in progress.
//  - ldr_wr while ldr_oe=0: ignored, no ack.
//  - Latency:
//    -- even byte: ack 2 cycles after ldr_wr is sampled;
//    -- odd byte: ack 2 cycles after mem_ack.
//  - mem_ack outside REQ is ignored. Address arithmetic is unsigned and wraps modulo 2^MEM_AW.
//  - busy = (state!=IDLE) | partial_valid.
// CONFIGURATION
//  LOADER_CHKSUM_EN defined:
//    - adds port chksum out 16;
//    - chksum = sum of accepted bytes mod 2^16, updated on each ldr_ack;
//    - cleared on rising ldr_oe and on reset.
//  LOADER_CHKSUM_EN undefined: port and adder absent, rest identical.
// STRUCTURE
//  Package pc88_ldr_pkg:
//    - state enum ldr_state_e;
//    - BE_LO=2'b01, BE_HI=2'b10, BE_W=2'b11;
//    - default ADDR_W/MEM_AW localparams.
//  Sub-module pc88_ldr_pack: lane register, word-address compare, partial_valid flag.
//  Top holds the FSM, mem handshake, counters.
// TESTING
//  1. Bytes 0x11@0, 0x22@1, mem_ack 3 cycles after req
//     -> one write: adr=BASE, wdat=0x2211, be=11; two acks; wr_count=1.
//  2. Byte 0x33@5 alone -> write adr=BASE+2, wdat[15:8]=0x33, be=10; one ack.
//  3. 0x44@8 then 0x55@12 -> flush adr=BASE+4, be=01, wdat[7:0]=0x44; then 0x55 held; ldr_done flushes BASE+6, be=01.
//  4. Shell-model loop of 1024 sequential bytes, random mem_ack delay 1-8
//     -> 512 writes, every word correct, no lost/duplicate ack.
//  5. rstn low while mem_req=1 -> all outputs 0 same cycle; after release a new byte restarts cleanly.
//  6. (LOADER_CHKSUM_EN) bytes 0xFF x 300 -> chksum=0x2A' d76500 mod 2^16 = 0x2AD4; new ldr_oe rise -> 0.

Source files
------------

// File: rtl/pc88_ldr_pkg.sv
// Shared types and constants for the PC-88 loader-to-SDRAM bridge.
package pc88_ldr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PACK,
        REQ,
        ACKB,
        FLUSH
    } ldr_state_e;

    localparam logic [1:0] BE_LO = 2'b01;
    localparam logic [1:0] BE_HI = 2'b10;
    localparam logic [1:0] BE_W  = 2'b11;

    localparam int LDR_ADDR_W = 19;
    localparam int LDR_MEM_AW = 22;

endpackage

// File: rtl/pc88_ldr_pack.sv
// Even-byte lane register: holds one low byte and its word address until paired or flushed.
module pc88_ldr_pack
    import pc88_ldr_pkg::*;
#(
    parameter int WA_W = LDR_ADDR_W - 1
) (
    input  logic            clk21m,
    input  logic            rstn,
    input  logic            load,
    input  logic            clear,
    input  logic [7:0]      lo_in,
    input  logic [WA_W-1:0] wadr_in,
    output logic [7:0]      lo_byte,
    output logic [WA_W-1:0] hold_wadr,
    output logic            partial_valid,
    output logic            match
);

    assign match = partial_valid && (hold_wadr == wadr_in);

    always_ff @(posedge clk21m or negedge rstn) begin
        if (!rstn) begin
            lo_byte       <= '0;
            hold_wadr     <= '0;
            partial_valid <= 1'b0;
        end else if (load) begin
            lo_byte       <= lo_in;
            hold_wadr     <= wadr_in;
            partial_valid <= 1'b1;
        end else if (clear) begin
            partial_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pc88_loader_sdram_bridge.sv
// Packs byte-wide loader writes into 16-bit SDRAM word writes, one loader ack per byte.
// Optional LOADER_CHKSUM_EN adds a running 16-bit byte checksum output.
module pc88_loader_sdram_bridge
    import pc88_ldr_pkg::*;
#(
    parameter int ADDR_W = LDR_ADDR_W,
    parameter int MEM_AW = LDR_MEM_AW,
    parameter int BASE   = 0
) (
    input  logic              clk21m,
    input  logic              rstn,
    input  logic              ldr_oe,
    input  logic [ADDR_W-1:0] ldr_adr,
    input  logic [7:0]        ldr_wdat,
    input  logic              ldr_wr,
    output logic              ldr_ack,
    input  logic              ldr_done,
    output logic              mem_req,
    output logic [MEM_AW-1:0] mem_adr,
    output logic [15:0]       mem_wdat,
    output logic [1:0]        mem_be,
    input  logic              mem_ack,
    output logic              busy,
    output logic [15:0]       wr_count
`ifdef LOADER_CHKSUM_EN
   ,output logic [15:0]       chksum
`endif
);

    localparam int WA_W = ADDR_W - 1;

    ldr_state_e        state, state_n;
    logic              req_n, ack_n, cnt_inc, pk_load, pk_clear;
    logic [MEM_AW-1:0] adr_n;
    logic [15:0]       wdat_n;
    logic [1:0]        be_n;
    logic              oe_q, done_q, flush_pend;
    logic [7:0]        lo_byte;
    logic [WA_W-1:0]   hold_wadr, cur_wadr;
    logic              partial_valid, match, take;

    function automatic logic [MEM_AW-1:0] to_mem(input logic [WA_W-1:0] wa);
        return MEM_AW'(BASE) + MEM_AW'(wa);
    endfunction

    assign cur_wadr = ldr_adr[ADDR_W-1:1];
    // The cycle carrying ldr_ack still sees the old ldr_wr, so it must not be taken.
    assign take     = ldr_wr & ldr_oe & ~ldr_ack;
    assign busy     = (state != IDLE) | partial_valid;

    pc88_ldr_pack #(.WA_W(WA_W)) u_pack (
        .clk21m        (clk21m),
        .rstn          (rstn),
        .load          (pk_load),
        .clear         (pk_clear),
        .lo_in         (ldr_wdat),
        .wadr_in       (cur_wadr),
        .lo_byte       (lo_byte),
        .hold_wadr     (hold_wadr),
        .partial_valid (partial_valid),
        .match         (match)
    );

    always_comb begin
        state_n  = state;
        req_n    = mem_req;
        adr_n    = mem_adr;
        wdat_n   = mem_wdat;
        be_n     = mem_be;
        ack_n    = 1'b0;
        cnt_inc  = 1'b0;
        pk_load  = 1'b0;
        pk_clear = 1'b0;
        unique case (state)
            IDLE: begin
                // Orphan low byte goes out first; a waiting byte stays un-acked meanwhile.
                if (partial_valid && (flush_pend || (take && !match))) begin
                    state_n = FLUSH;
                    req_n   = 1'b1;
                    adr_n   = to_mem(hold_wadr);
                    wdat_n  = {8'h00, lo_byte};
                    be_n    = BE_LO;
                end else if (take && !ldr_adr[0]) begin
                    pk_load = 1'b1;
                    state_n = PACK;
                end else if (take) begin
                    state_n = REQ;
                    req_n   = 1'b1;
                    adr_n   = to_mem(cur_wadr);
                    wdat_n  = {ldr_wdat, match ? lo_byte : 8'h00};
                    be_n    = match ? BE_W : BE_HI;
                end
            end
            PACK: begin
                ack_n   = 1'b1;
                state_n = IDLE;
            end
            REQ: begin
                if (mem_ack) begin
                    req_n   = 1'b0;
                    cnt_inc = 1'b1;
                    state_n = ACKB;
                end
            end
            ACKB: begin
                ack_n    = 1'b1;
                pk_clear = 1'b1;
                state_n  = IDLE;
            end
            FLUSH: begin
                if (mem_ack) begin
                    req_n    = 1'b0;
                    cnt_inc  = 1'b1;
                    pk_clear = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk21m or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_adr    <= '0;
            mem_wdat   <= '0;
            mem_be     <= '0;
            ldr_ack    <= 1'b0;
            wr_count   <= '0;
            oe_q       <= 1'b0;
            done_q     <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            state    <= state_n;
            mem_req  <= req_n;
            mem_adr  <= adr_n;
            mem_wdat <= wdat_n;
            mem_be   <= be_n;
            ldr_ack  <= ack_n;
            oe_q     <= ldr_oe;
            done_q   <= ldr_done;
            if (cnt_inc) wr_count <= wr_count + 16'd1;
            // End-of-download events are remembered until the FSM is idle to act on them.
            if ((ldr_done & ~done_q) | (oe_q & ~ldr_oe))
                flush_pend <= 1'b1;
            else if (state == IDLE && !partial_valid)
                flush_pend <= 1'b0;
        end
    end

`ifdef LOADER_CHKSUM_EN
    logic [7:0] cur_byte;

    always_ff @(posedge clk21m or negedge rstn) begin
        if (!rstn) begin
            cur_byte <= '0;
            chksum   <= '0;
        end else begin
            if (state == IDLE && take) cur_byte <= ldr_wdat;
            if (ldr_oe & ~oe_q)
                chksum <= '0;
            else if (ack_n)
                chksum <= chksum + {8'h00, cur_byte};
        end
    end
`endif

endmodule

// File: tb/tb_pc88_loader_sdram_bridge.sv
// Scoreboard bench: expected SDRAM writes queued at stimulus time, checked by the memory responder.
module tb_pc88_loader_sdram_bridge;

    localparam int BASE = 16;

    typedef struct packed {
        logic [21:0] adr;
        logic [15:0] wdat;
        logic [1:0]  be;
    } wr_t;

    logic        clk21m = 1'b0;
    logic        rstn = 1'b0;
    logic        ldr_oe = 1'b0;
    logic [18:0] ldr_adr = '0;
    logic [7:0]  ldr_wdat = '0;
    logic        ldr_wr = 1'b0;
    logic        ldr_done = 1'b0;
    logic        mem_ack = 1'b0;
    logic        ldr_ack, mem_req, busy;
    logic [21:0] mem_adr;
    logic [15:0] mem_wdat, wr_count;
    logic [1:0]  mem_be;
`ifdef LOADER_CHKSUM_EN
    logic [15:0] chksum;
`endif

    int   checks = 0;
    int   failures = 0;
    int   ack_cnt = 0;
    logic ack_q = 1'b0;
    int   fix_dly = 3;
    bit   rand_dly = 1'b0;
    wr_t  exp_q[$];
    wr_t  r_e;
    int   r_d;
    logic [15:0] r_m;

    pc88_loader_sdram_bridge #(.ADDR_W(19), .MEM_AW(22), .BASE(BASE)) dut (
        .clk21m   (clk21m),
        .rstn     (rstn),
        .ldr_oe   (ldr_oe),
        .ldr_adr  (ldr_adr),
        .ldr_wdat (ldr_wdat),
        .ldr_wr   (ldr_wr),
        .ldr_ack  (ldr_ack),
        .ldr_done (ldr_done),
        .mem_req  (mem_req),
        .mem_adr  (mem_adr),
        .mem_wdat (mem_wdat),
        .mem_be   (mem_be),
        .mem_ack  (mem_ack),
        .busy     (busy),
        .wr_count (wr_count)
`ifdef LOADER_CHKSUM_EN
       ,.chksum   (chksum)
`endif
    );

    always #5 clk21m = ~clk21m;

    function automatic wr_t mk(input int wa, input logic [15:0] wd, input logic [1:0] be);
        wr_t w;
        w.adr  = 22'(BASE + wa);
        w.wdat = wd;
        w.be   = be;
        return w;
    endfunction

    // SDRAM model: pops the expected write when a request appears, holds it, then pulses mem_ack.
    initial begin
        forever begin
            @(posedge clk21m); #1;
            if (rstn && mem_req) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL wr_unexpected adr=%h wdat=%h be=%b", mem_adr, mem_wdat, mem_be);
                    r_e = {mem_adr, mem_wdat, mem_be};
                end else begin
                    r_e = exp_q.pop_front();
                    r_m = {{8{r_e.be[1]}}, {8{r_e.be[0]}}};
                    if (mem_adr !== r_e.adr || mem_be !== r_e.be || (mem_wdat & r_m) !== (r_e.wdat & r_m)) begin
                        failures++;
                        $display("FAIL wr_data got adr=%h wdat=%h be=%b want adr=%h wdat=%h be=%b",
                                 mem_adr, mem_wdat, mem_be, r_e.adr, r_e.wdat, r_e.be);
                    end
                end
                r_d = rand_dly ? int'($urandom_range(8, 1)) : fix_dly;
                for (int i = 1; i < r_d; i++) begin
                    @(posedge clk21m); #1;
                    if (!rstn) break;
                    checks++;
                    if (mem_req !== 1'b1 || mem_adr !== r_e.adr || mem_be !== r_e.be) begin
                        failures++;
                        $display("FAIL req_hold req=%b adr=%h be=%b want adr=%h be=%b",
                                 mem_req, mem_adr, mem_be, r_e.adr, r_e.be);
                    end
                end
                if (rstn) begin
                    mem_ack = 1'b1;
                    @(posedge clk21m); #1;
                    mem_ack = 1'b0;
                end
            end
        end
    end

    always @(negedge clk21m) begin
        if (ldr_ack) begin
            ack_cnt++;
            checks++;
            if (ack_q) begin
                failures++;
                $display("FAIL ack_pulse ldr_ack high two cycles, want one");
            end
        end
        ack_q = ldr_ack;
    end

    // Shell model: hold wr until ack, keep it one more edge, then release.
    task automatic send_byte(input logic [18:0] a, input logic [7:0] d);
        int n = 0;
        ldr_adr  = a;
        ldr_wdat = d;
        ldr_wr   = 1'b1;
        do begin
            @(negedge clk21m);
            n++;
        end while (!ldr_ack && n < 300);
        if (!ldr_ack) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout adr=%h got no ack want ack", a);
        end
        @(posedge clk21m); #1;
        ldr_wr = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk21m);
            n++;
        end while ((busy || mem_req) && n < 300);
        if (busy || mem_req) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout busy=%b req=%b want 0", busy, mem_req);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk21m);
        checks++;
        if ({mem_req, ldr_ack, busy} !== 3'b000 || mem_adr !== '0 || mem_wdat !== '0 ||
            mem_be !== '0 || wr_count !== '0) begin
            failures++;
            $display("FAIL reset req=%b ack=%b busy=%b adr=%h wdat=%h be=%b cnt=%0d want all 0",
                     mem_req, ldr_ack, busy, mem_adr, mem_wdat, mem_be, wr_count);
        end
        rstn   = 1'b1;
        ldr_oe = 1'b1;
        @(negedge clk21m);
    endtask

    task automatic test_pair();
        int a0, n;
        a0 = ack_cnt;
        fix_dly = 3;
        exp_q.push_back(mk(0, 16'h2211, 2'b11));
        ldr_adr = 19'd0; ldr_wdat = 8'h11; ldr_wr = 1'b1;
        @(posedge clk21m);
        @(negedge clk21m);
        checks++;
        if (ldr_ack !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL even_lat1 ack=%b busy=%b want ack=0 busy=1", ldr_ack, busy);
        end
        @(negedge clk21m);
        checks++;
        if (ldr_ack !== 1'b1) begin
            failures++;
            $display("FAIL even_lat2 ack=%b want 1", ldr_ack);
        end
        @(posedge clk21m); #1;
        ldr_adr = 19'd1; ldr_wdat = 8'h22;
        n = 0;
        do begin
            @(negedge clk21m);
            n++;
        end while (!mem_ack && n < 50);
        @(negedge clk21m);
        checks++;
        if (mem_req !== 1'b0 || ldr_ack !== 1'b0) begin
            failures++;
            $display("FAIL odd_lat1 req=%b ack=%b want req=0 ack=0", mem_req, ldr_ack);
        end
        @(negedge clk21m);
        checks++;
        if (ldr_ack !== 1'b1) begin
            failures++;
            $display("FAIL odd_lat2 ack=%b want 1", ldr_ack);
        end
        @(posedge clk21m); #1;
        ldr_wr = 1'b0;
        @(negedge clk21m);
        checks++;
        if (wr_count !== 16'd1 || ack_cnt - a0 != 2 || busy !== 1'b0) begin
            failures++;
            $display("FAIL pair_count cnt=%0d acks=%0d busy=%b want cnt=1 acks=2 busy=0",
                     wr_count, ack_cnt - a0, busy);
        end
    endtask

    task automatic test_single_odd();
        int a0;
        a0 = ack_cnt;
        exp_q.push_back(mk(2, 16'h3300, 2'b10));
        send_byte(19'd5, 8'h33);
        wait_idle();
        checks++;
        if (wr_count !== 16'd2 || ack_cnt - a0 != 1) begin
            failures++;
            $display("FAIL odd_alone cnt=%0d acks=%0d want cnt=2 acks=1", wr_count, ack_cnt - a0);
        end
    endtask

    task automatic test_flush();
        int a0;
        a0 = ack_cnt;
        send_byte(19'd8, 8'h44);
        exp_q.push_back(mk(4, 16'h0044, 2'b01));
        send_byte(19'd12, 8'h55);
        checks++;
        if (wr_count !== 16'd3 || busy !== 1'b1) begin
            failures++;
            $display("FAIL flush_addr cnt=%0d busy=%b want cnt=3 busy=1", wr_count, busy);
        end
        exp_q.push_back(mk(6, 16'h0055, 2'b01));
        ldr_done = 1'b1;
        wait_idle();
        ldr_done = 1'b0;
        checks++;
        if (wr_count !== 16'd4 || ack_cnt - a0 != 2) begin
            failures++;
            $display("FAIL flush_done cnt=%0d acks=%0d want cnt=4 acks=2", wr_count, ack_cnt - a0);
        end
    endtask

    task automatic test_oe();
        int a0;
        a0 = ack_cnt;
        ldr_oe = 1'b0;
        ldr_adr = 19'd100; ldr_wdat = 8'hAA; ldr_wr = 1'b1;
        repeat (5) @(negedge clk21m);
        checks++;
        if (ack_cnt != a0 || busy !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL oe_gate acks=%0d busy=%b req=%b want 0", ack_cnt - a0, busy, mem_req);
        end
        ldr_wr = 1'b0;
        ldr_oe = 1'b1;
        @(negedge clk21m);
        send_byte(19'd40, 8'h99);
        exp_q.push_back(mk(20, 16'h0099, 2'b01));
        @(negedge clk21m);
        ldr_oe = 1'b0;
        wait_idle();
        checks++;
        if (wr_count !== 16'd5) begin
            failures++;
            $display("FAIL oe_flush cnt=%0d want 5", wr_count);
        end
        ldr_oe = 1'b1;
        @(negedge clk21m);
    endtask

    task automatic test_stream();
        int a0;
        logic [7:0] lo, hi;
        a0 = ack_cnt;
        rand_dly = 1'b1;
        for (int i = 0; i < 512; i++) begin
            lo = 8'($urandom_range(255, 0));
            hi = 8'($urandom_range(255, 0));
            exp_q.push_back(mk(32 + i, {hi, lo}, 2'b11));
            send_byte(19'(64 + 2 * i), lo);
            send_byte(19'(65 + 2 * i), hi);
        end
        wait_idle();
        rand_dly = 1'b0;
        checks++;
        if (wr_count !== 16'd517 || ack_cnt - a0 != 1024 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL stream cnt=%0d acks=%0d left=%0d want cnt=517 acks=1024 left=0",
                     wr_count, ack_cnt - a0, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int n;
        fix_dly = 8;
        exp_q.push_back(mk(10, 16'h6600, 2'b10));
        ldr_adr = 19'd21; ldr_wdat = 8'h66; ldr_wr = 1'b1;
        n = 0;
        do begin
            @(negedge clk21m);
            n++;
        end while (!mem_req && n < 50);
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_req req=%b want 1", mem_req);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({mem_req, ldr_ack, busy} !== 3'b000 || mem_adr !== '0 || mem_wdat !== '0 ||
            mem_be !== '0 || wr_count !== '0) begin
            failures++;
            $display("FAIL rst_async req=%b ack=%b busy=%b adr=%h be=%b cnt=%0d want all 0",
                     mem_req, ldr_ack, busy, mem_adr, mem_be, wr_count);
        end
        ldr_wr = 1'b0;
        @(negedge clk21m);
        rstn = 1'b1;
        fix_dly = 2;
        @(negedge clk21m);
        exp_q.push_back(mk(0, 16'h7877, 2'b11));
        send_byte(19'd0, 8'h77);
        send_byte(19'd1, 8'h78);
        wait_idle();
        checks++;
        if (wr_count !== 16'd1) begin
            failures++;
            $display("FAIL rst_restart cnt=%0d want 1", wr_count);
        end
    endtask

`ifdef LOADER_CHKSUM_EN
    task automatic test_chksum();
        ldr_oe = 1'b0;
        @(negedge clk21m);
        ldr_oe = 1'b1;
        repeat (2) @(negedge clk21m);
        checks++;
        if (chksum !== 16'h0000) begin
            failures++;
            $display("FAIL chk_clear got=%h want 0000", chksum);
        end
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) exp_q.push_back(mk(100 + i / 2, 16'hFFFF, 2'b11));
            send_byte(19'(200 + i), 8'hFF);
        end
        wait_idle();
        checks++;
        if (chksum !== 16'h2AD4) begin
            failures++;
            $display("FAIL chk_sum got=%h want 2ad4", chksum);
        end
        ldr_oe = 1'b0;
        @(negedge clk21m);
        ldr_oe = 1'b1;
        repeat (2) @(negedge clk21m);
        checks++;
        if (chksum !== 16'h0000) begin
            failures++;
            $display("FAIL chk_oe_rise got=%h want 0000", chksum);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_pair();
        test_single_odd();
        test_flush();
        test_oe();
        test_stream();
        test_reset_mid();
`ifdef LOADER_CHKSUM_EN
        test_chksum();
`endif
        repeat (4) @(negedge clk21m);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL wr_missing left=%0d want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
